// File: rtl/add_float_serial.sv
// add_float_serial: bit-serial IEEE-754 single-precision adder, serial in/out around a parallel datapath.
// Define ADD_FLOAT_ROUND_NEAREST_EN for round-to-nearest-even; otherwise results are truncated.
module add_float_serial #(
  parameter int W     = 32,
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic clk,
  input  logic reset,
  input  logic go,
  input  logic inpab,
  output logic shift,
  output logic out_c,
  output logic over,
  output logic under,
  output logic done
);
  localparam int GW = MAN_W + 4;  // hidden bit + fraction + guard/round/sticky
  localparam int XW = EXP_W + 2;  // signed exponent with headroom for carry and borrow
  localparam logic [W-1:0] QNAN = W'(32'h7FC0_0000);
  localparam logic signed [XW-1:0] S_ONE  = XW'(1);
  localparam logic signed [XW-1:0] S_ZERO = '0;
  localparam logic signed [XW-1:0] S_EMAX = XW'((1 << EXP_W) - 1);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LOAD   = 4'd1;
  localparam logic [3:0] S_UNPACK = 4'd2;
  localparam logic [3:0] S_ALIGN  = 4'd3;
  localparam logic [3:0] S_ADD    = 4'd4;
  localparam logic [3:0] S_NORM   = 4'd5;
  localparam logic [3:0] S_PACK   = 4'd6;
  localparam logic [3:0] S_OUTPUT = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  function automatic logic [4:0] lzc(input logic [GW-1:0] v);
    logic [4:0] n;
    n = 5'(GW);
    for (int i = 0; i < GW; i++)
      if (v[i]) n = 5'(GW - 1 - i);
    return n;
  endfunction

  function automatic logic [MAN_W+1:0] round_man(input logic [GW-1:0] m);
`ifdef ADD_FLOAT_ROUND_NEAREST_EN
    logic up;
    up = m[2] & (m[1] | m[0] | m[3]);
    return {1'b0, m[GW-1:3]} + {{(MAN_W+1){1'b0}}, up};
`else
    return {1'b0, m[GW-1:3]};
`endif
  endfunction

  logic [3:0]       state;
  logic [5:0]       cnt;
  logic [2*W-1:0]   ab_sr;
  logic [W-1:0]     c_sr;

  logic             sa_p0, sb_p0, spc_p0;
  logic [EXP_W-1:0] ea_p0, eb_p0;
  logic [MAN_W:0]   ma_p0, mb_p0;
  logic [W-1:0]     spcw_p0;
  logic             sign_p1, sub_p1;
  logic [EXP_W-1:0] exp_p1;
  logic [GW-1:0]    ml_p1, ms_p1;
  logic             sign_p2;
  logic [EXP_W-1:0] exp_p2;
  logic [GW:0]      sum_p2;
  logic             sign_p3;
  logic signed [XW-1:0] nexp_p3;
  logic [GW-1:0]    nman_p3;

  // Unpack: split fields, flush zero-exponent operands, resolve special operands up front.
  logic [W-1:0]     a_w, b_w, spcw_c;
  logic [EXP_W-1:0] ea_c, eb_c;
  logic [MAN_W:0]   ma_c, mb_c;
  logic             nan_a, nan_b, inf_a, inf_b, spc_c;

  always_comb begin
    a_w    = ab_sr[2*W-1:W];
    b_w    = ab_sr[W-1:0];
    ea_c   = a_w[W-2 -: EXP_W];
    eb_c   = b_w[W-2 -: EXP_W];
    ma_c   = (ea_c == '0) ? '0 : {1'b1, a_w[MAN_W-1:0]};
    mb_c   = (eb_c == '0) ? '0 : {1'b1, b_w[MAN_W-1:0]};
    nan_a  = (ea_c == '1) && (a_w[MAN_W-1:0] != '0);
    nan_b  = (eb_c == '1) && (b_w[MAN_W-1:0] != '0);
    inf_a  = (ea_c == '1) && (a_w[MAN_W-1:0] == '0);
    inf_b  = (eb_c == '1) && (b_w[MAN_W-1:0] == '0);
    spc_c  = (ea_c == '1) || (eb_c == '1);
    spcw_c = '0;
    if (nan_a || nan_b || (inf_a && inf_b && (a_w[W-1] != b_w[W-1]))) spcw_c = QNAN;
    else if (inf_a) spcw_c = a_w;
    else if (inf_b) spcw_c = b_w;
  end

  // Align: larger magnitude first; smaller mantissa shifted right with sticky collection.
  logic             a_ge, sl_c;
  logic [EXP_W-1:0] el_c, es_c, diff_c;
  logic [MAN_W:0]   ml_c, ms_c;
  logic [2*GW-1:0]  wide_c;
  logic [GW-1:0]    ms_al_c;

  always_comb begin
    a_ge   = {ea_p0, ma_p0} >= {eb_p0, mb_p0};
    el_c   = a_ge ? ea_p0 : eb_p0;
    es_c   = a_ge ? eb_p0 : ea_p0;
    ml_c   = a_ge ? ma_p0 : mb_p0;
    ms_c   = a_ge ? mb_p0 : ma_p0;
    sl_c   = a_ge ? sa_p0 : sb_p0;
    diff_c = el_c - es_c;
    wide_c = {ms_c, 3'b000, {GW{1'b0}}} >> diff_c;
    if (diff_c > EXP_W'(GW - 1))
      ms_al_c = {{(GW-1){1'b0}}, |ms_c};
    else
      ms_al_c = wide_c[2*GW-1:GW] | {{(GW-1){1'b0}}, |wide_c[GW-1:0]};
  end

  // Normalize: carry-out shifts right keeping sticky, otherwise shift left by leading zeros.
  logic [4:0]           lz_c;
  logic signed [XW-1:0] nexp_c;
  logic [GW-1:0]        nman_c;

  always_comb begin
    lz_c = lzc(sum_p2[GW-1:0]);
    if (sum_p2[GW]) begin
      nman_c = {sum_p2[GW:2], sum_p2[1] | sum_p2[0]};
      nexp_c = $signed({2'b00, exp_p2}) + S_ONE;
    end else begin
      nman_c = sum_p2[GW-1:0] << lz_c;
      nexp_c = $signed({2'b00, exp_p2}) - $signed({{(XW-5){1'b0}}, lz_c});
    end
  end

  // Pack: round, then classify zero / overflow / underflow; special operands override.
  logic [MAN_W+1:0]     rnd_c;
  logic signed [XW-1:0] pexp_c;
  logic [MAN_W-1:0]     pman_c;
  logic [W-1:0]         c_pack;
  logic                 ov_c, un_c;

  always_comb begin
    rnd_c  = round_man(nman_p3);
    pexp_c = nexp_p3 + (rnd_c[MAN_W+1] ? S_ONE : S_ZERO);
    pman_c = rnd_c[MAN_W+1] ? rnd_c[MAN_W:1] : rnd_c[MAN_W-1:0];
    c_pack = '0;
    ov_c   = 1'b0;
    un_c   = 1'b0;
    if (spc_p0) begin
      c_pack = spcw_p0;
    end else if (nman_p3 == '0) begin
      c_pack = '0;
    end else if (pexp_c >= S_EMAX) begin
      c_pack = {sign_p3, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ov_c   = 1'b1;
    end else if (pexp_c <= S_ZERO) begin
      c_pack = {sign_p3, {(W-1){1'b0}}};
      un_c   = 1'b1;
    end else begin
      c_pack = {sign_p3, pexp_c[EXP_W-1:0], pman_c};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ab_sr   <= '0;
      c_sr    <= '0;
      over    <= 1'b0;
      under   <= 1'b0;
      sa_p0   <= 1'b0;
      sb_p0   <= 1'b0;
      spc_p0  <= 1'b0;
      ea_p0   <= '0;
      eb_p0   <= '0;
      ma_p0   <= '0;
      mb_p0   <= '0;
      spcw_p0 <= '0;
      sign_p1 <= 1'b0;
      sub_p1  <= 1'b0;
      exp_p1  <= '0;
      ml_p1   <= '0;
      ms_p1   <= '0;
      sign_p2 <= 1'b0;
      exp_p2  <= '0;
      sum_p2  <= '0;
      sign_p3 <= 1'b0;
      nexp_p3 <= '0;
      nman_p3 <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!go) begin
            state <= S_LOAD;
            cnt   <= '0;
            over  <= 1'b0;
            under <= 1'b0;
          end
        end
        S_LOAD: begin
          ab_sr <= {ab_sr[2*W-2:0], inpab};
          cnt   <= cnt + 6'd1;
          if (cnt == 6'd63) state <= S_UNPACK;
        end
        S_UNPACK: begin
          sa_p0   <= a_w[W-1];
          sb_p0   <= b_w[W-1];
          ea_p0   <= ea_c;
          eb_p0   <= eb_c;
          ma_p0   <= ma_c;
          mb_p0   <= mb_c;
          spc_p0  <= spc_c;
          spcw_p0 <= spcw_c;
          state   <= S_ALIGN;
        end
        S_ALIGN: begin
          sign_p1 <= sl_c;
          sub_p1  <= sa_p0 ^ sb_p0;
          exp_p1  <= el_c;
          ml_p1   <= {ml_c, 3'b000};
          ms_p1   <= ms_al_c;
          state   <= S_ADD;
        end
        S_ADD: begin
          sign_p2 <= sign_p1;
          exp_p2  <= exp_p1;
          sum_p2  <= sub_p1 ? ({1'b0, ml_p1} - {1'b0, ms_p1}) : ({1'b0, ml_p1} + {1'b0, ms_p1});
          state   <= S_NORM;
        end
        S_NORM: begin
          sign_p3 <= sign_p2;
          nexp_p3 <= nexp_c;
          nman_p3 <= nman_c;
          state   <= S_PACK;
        end
        S_PACK: begin
          c_sr  <= c_pack;
          over  <= ov_c;
          under <= un_c;
          cnt   <= '0;
          state <= S_OUTPUT;
        end
        S_OUTPUT: begin
          c_sr <= {c_sr[W-2:0], 1'b0};
          cnt  <= cnt + 6'd1;
          if (cnt == 6'd31) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign shift = (state == S_OUTPUT);
  assign out_c = shift & c_sr[W-1];
  assign done  = (state == S_DONE);

endmodule

// File: tb/tb_add_float_serial.sv
// Directed bench for add_float_serial: a real-arithmetic reference model plus a per-cycle output monitor.
module tb_add_float_serial;
  logic clk = 1'b0;
  logic reset, go, inpab;
  logic shift, out_c, over, under, done;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_c;
  logic        exp_ov, exp_un;
  logic [31:0] got_c;
  int          nbits;

  add_float_serial dut (
    .clk(clk), .reset(reset), .go(go), .inpab(inpab),
    .shift(shift), .out_c(out_c), .over(over), .under(under), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic real to_real(input logic [31:0] x);
    real m;
    int  e;
    e = int'(x[30:23]);
    if (e == 0) return 0.0;
    m = real'({1'b1, x[22:0]});
    e = e - 150;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return x[31] ? -m : m;
  endfunction

  // Exact sum in double precision (operands within 29 exponent steps), then re-rounded to single.
  task automatic model_add(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] c, output logic ov, output logic un);
    logic        nan_a, nan_b, inf_a, inf_b, sgn, g, rs;
    logic [63:0] bits;
    logic [24:0] man;
    real         d;
    int          e;
    nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    inf_a = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    inf_b = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    c = 32'h0; ov = 1'b0; un = 1'b0;
    if (nan_a || nan_b || (inf_a && inf_b && a[31] != b[31])) c = 32'h7FC00000;
    else if (inf_a) c = a;
    else if (inf_b) c = b;
    else begin
      d = to_real(a) + to_real(b);
      if (d != 0.0) begin
        bits = $realtobits(d);
        sgn  = bits[63];
        e    = int'(bits[62:52]) - 896;
        man  = {2'b01, bits[51:29]};
        g    = bits[28];
        rs   = |bits[27:0];
`ifdef ADD_FLOAT_ROUND_NEAREST_EN
        if (g && (rs || man[0])) man = man + 25'd1;
        if (man[24]) begin man = man >> 1; e++; end
`endif
        if (e >= 255) begin c = {sgn, 8'hFF, 23'h0}; ov = 1'b1; end
        else if (e <= 0) begin c = {sgn, 31'h0}; un = 1'b1; end
        else c = {sgn, e[7:0], man[22:0]};
      end
    end
  endtask

  // Output monitor: assembles each serial word and checks every cycle's idle/active behaviour.
  initial begin
    nbits = 0;
    got_c = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        nbits = 0;
      end else begin
        if (shift) begin
          if (nbits == 0) begin
            check("over_first", 32'(over), 32'(exp_ov));
            check("under_first", 32'(under), 32'(exp_un));
          end
          got_c = {got_c[30:0], out_c};
          nbits++;
        end else begin
          check("out_c_idle", 32'(out_c), 32'h0);
        end
        if (done) begin
          check("bit_count", 32'(nbits), 32'd32);
          check("c_word", got_c, exp_c);
          nbits = 0;
        end
      end
    end
  end

  task automatic load_ab(input logic [31:0] a, input logic [31:0] b, input bit wiggle);
    logic [63:0] ab;
    ab = {a, b};
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    go = 1'b1;
    for (int i = 63; i >= 0; i--) begin
      inpab = ab[i];
      if (wiggle) go = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    go = 1'b1;
    inpab = 1'b0;
  endtask

  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input bit wiggle);
    int lat, n;
    model_add(a, b, exp_c, exp_ov, exp_un);
    load_ab(a, b, wiggle);
    lat = 0;
    while (!shift && lat < 20) begin @(negedge clk); lat++; end
    check("latency", 32'(lat), 32'd5);
    n = 0;
    while (!done && n < 60) begin @(negedge clk); n++; end
    check("done_seen", 32'(done), 32'h1);
    @(negedge clk);
    check("done_single", 32'(done), 32'h0);
    check("over_hold", 32'(over), 32'(exp_ov));
    check("under_hold", 32'(under), 32'(exp_un));
  endtask

  localparam int NV = 15;
  logic [31:0] va [NV] = '{32'hF8780000, 32'h3F800000, 32'h3F800000, 32'h7F7FFFFF, 32'h00800000,
                           32'h4B800000, 32'h3FC00000, 32'h7F800000, 32'h7F800000, 32'h7F800001,
                           32'h00000000, 32'h00400000, 32'hC0A00000, 32'h3F800001, 32'h3F800001};
  logic [31:0] vb [NV] = '{32'h73840000, 32'hBF800000, 32'h3F800000, 32'h7F7FFFFF, 32'h80C00000,
                           32'h40400000, 32'h40100000, 32'h3F800000, 32'hFF800000, 32'h00000000,
                           32'h80000000, 32'h3F800000, 32'h40400000, 32'h33800000, 32'hBF800000};

  initial begin
    logic [31:0] c;
    logic        o, u;
    int          n;
    reset = 1'b0; go = 1'b1; inpab = 1'b0;
    exp_c = '0; exp_ov = 1'b0; exp_un = 1'b0;
    #1;
    check("reset_outputs", {27'h0, shift, out_c, over, under, done}, 32'h0);

    // Pin the reference model to hand-computed results.
    model_add(32'hF8780000, 32'h73840000, c, o, u); check("model_sub_far", c, 32'hF877BE00);
    model_add(32'h3F800000, 32'hBF800000, c, o, u); check("model_cancel", c, 32'h00000000);
    model_add(32'h3F800000, 32'h3F800000, c, o, u); check("model_one_one", c, 32'h40000000);
    model_add(32'h7F7FFFFF, 32'h7F7FFFFF, c, o, u); check("model_ovf", c, 32'h7F800000);
    check("model_ovf_flag", 32'(o), 32'h1);
    model_add(32'h00800000, 32'h80C00000, c, o, u); check("model_unf", c, 32'h80000000);
    check("model_unf_flag", 32'(u), 32'h1);
    model_add(32'h7F800000, 32'hFF800000, c, o, u); check("model_inf_nan", c, 32'h7FC00000);
    model_add(32'h4B800000, 32'h40400000, c, o, u);
`ifdef ADD_FLOAT_ROUND_NEAREST_EN
    check("model_round", c, 32'h4B800002);
`else
    check("model_round", c, 32'h4B800001);
`endif

    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) run_txn(va[i], vb[i], 1'b0);
    run_txn(32'hF8780000, 32'h73840000, 1'b1);

    // Abort in the middle of the serial output, then run a clean transaction.
    model_add(32'h3FC00000, 32'h40100000, exp_c, exp_ov, exp_un);
    load_ab(32'h3FC00000, 32'h40100000, 1'b0);
    n = 0;
    while (!shift && n < 20) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1 check("abort_outputs", {29'h0, shift, out_c, done}, 32'h0);
    check("abort_flags", {30'h0, over, under}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_txn(32'h4B800000, 32'h40400000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
